// File: rtl/sid_pkg.sv
// Shared types and constants for the SID PDM audio back-end.
//   sid_state_e : modulator power state (OFF, RAMP, RUN, FALL)
//   SAMPLE_MAX  : full-scale code for the default 12-bit sample width
//   sample_max  : full-scale code for an arbitrary sample width
//   LFSR_SEED / LFSR_TAPS : dither generator reset value and Galois mask
package sid_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RAMP = 2'd1,
        RUN  = 2'd2,
        FALL = 2'd3
    } sid_state_e;

    localparam int unsigned SID_SAMPLE_W = 12;
    localparam int unsigned SAMPLE_MAX   = (1 << SID_SAMPLE_W) - 1;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int unsigned sample_max(input int unsigned w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/sid_sdm_ch.sv
// Single-channel first-order sigma-delta accumulator.
//   clk_i, rst_i : clock and synchronous active-high reset
//   tick_i       : advance the modulator one step
//   clr_i        : force accumulator and output to zero (wins over tick_i)
//   eff_i        : ramp-limited sample to modulate
//   cin_i        : carry-in to the sum (dither bit, 0 when unused)
//   pdm_o        : 1-bit density-modulated output, ones density = eff/2^SAMPLE_W
module sid_sdm_ch
    import sid_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 12
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                tick_i,
    input  logic                clr_i,
    input  logic [SAMPLE_W-1:0] eff_i,
    input  logic                cin_i,
    output logic                pdm_o
);

    logic [SAMPLE_W-1:0] acc_q;
    logic                pdm_q;
    logic [SAMPLE_W:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, eff_i} + {{SAMPLE_W{1'b0}}, cin_i};

    // The carry out of the accumulator is the PDM bit.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            acc_q <= '0;
            pdm_q <= 1'b0;
        end else if (tick_i) begin
            acc_q <= sum[SAMPLE_W-1:0];
            pdm_q <= sum[SAMPLE_W];
        end
    end

    assign pdm_o = pdm_q;

endmodule

// File: rtl/sid_pdm_out.sv
// SID audio back-end: converts the two voice-mix samples into 1-bit PDM streams
// with a programmable modulator rate, optional mono mix and a soft-start/stop ramp.
//   clk_i, rst_i     : clock and synchronous active-high reset
//   sample_raw_1/2   : unsigned offset-binary samples from the SID core
//   enable_i         : 1 = ramp up and run, 0 = ramp down and stop
//   div_i            : modulator steps once every div_i+1 clocks
//   mono_i           : 1 = both channels carry (s1+s2)>>1
//   pdm_1_o, pdm_2_o : PDM streams
//   active_o         : high whenever the state is not OFF
//   tick_o           : one-clock pulse coincident with each PDM update
// Optional feature: define SID_PDM_DITHER_EN to add an LFSR carry-in dither.
module sid_pdm_out
    import sid_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 12,
    parameter int unsigned DIV_W    = 8,
    parameter int unsigned RAMP_INC = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [SAMPLE_W-1:0] sample_raw_1,
    input  logic [SAMPLE_W-1:0] sample_raw_2,
    input  logic                enable_i,
    input  logic [DIV_W-1:0]    div_i,
    input  logic                mono_i,
    output logic                pdm_1_o,
    output logic                pdm_2_o,
    output logic                active_o,
    output logic                tick_o
);

    localparam logic [SAMPLE_W-1:0] RampMax  = SAMPLE_W'(sample_max(SAMPLE_W));
    localparam logic [SAMPLE_W:0]   RampMaxW = {1'b0, RampMax};
    localparam logic [SAMPLE_W:0]   RampIncW = (SAMPLE_W+1)'(RAMP_INC);
    localparam logic [SAMPLE_W-1:0] RampInc  = SAMPLE_W'(RAMP_INC);

    sid_state_e          state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] ramp_q, ramp_d;
    logic                tick_q;

    logic                run;
    logic                tick;
    logic                clr;
    logic                cin;
    logic [SAMPLE_W:0]   mix_sum;
    logic [SAMPLE_W-1:0] c1, c2, eff_1, eff_2;
    logic [SAMPLE_W:0]   ramp_sum;
    logic [SAMPLE_W-1:0] ramp_up, ramp_dn;

    // Rate divider; idles at zero while fully stopped.
    assign run  = (state_q != OFF) || enable_i;
    assign tick = run && (cnt_q >= div_i);

    always_comb begin
        cnt_d = cnt_q;
        if (run) begin
            cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
        end
    end

    // Mixer: the sum keeps its carry so the halved mono mix never overflows.
    assign mix_sum = {1'b0, sample_raw_1} + {1'b0, sample_raw_2};
    assign c1      = mono_i ? mix_sum[SAMPLE_W:1] : sample_raw_1;
    assign c2      = mono_i ? mix_sum[SAMPLE_W:1] : sample_raw_2;

    // Ramp limit uses the pre-update ramp value.
    assign eff_1 = (c1 < ramp_q) ? c1 : ramp_q;
    assign eff_2 = (c2 < ramp_q) ? c2 : ramp_q;

    // Saturating ramp steps.
    assign ramp_sum = {1'b0, ramp_q} + RampIncW;
    assign ramp_up  = (ramp_sum > RampMaxW) ? RampMax : ramp_sum[SAMPLE_W-1:0];
    assign ramp_dn  = ({1'b0, ramp_q} > RampIncW) ? (ramp_q - RampInc) : '0;

    // OFF reacts to enable_i every clock; the other states move only on tick.
    always_comb begin
        state_d = state_q;
        ramp_d  = ramp_q;
        unique case (state_q)
            OFF: begin
                ramp_d = '0;
                if (enable_i) begin
                    state_d = RAMP;
                end
            end
            RAMP: begin
                if (tick) begin
                    if (!enable_i) begin
                        state_d = FALL;
                    end else begin
                        ramp_d = ramp_up;
                        if (ramp_up == RampMax) begin
                            state_d = RUN;
                        end
                    end
                end
            end
            RUN: begin
                if (tick) begin
                    ramp_d = RampMax;
                    if (!enable_i) begin
                        state_d = FALL;
                    end
                end
            end
            FALL: begin
                if (tick) begin
                    if (enable_i) begin
                        state_d = RAMP;
                    end else begin
                        ramp_d = ramp_dn;
                        if (ramp_dn == '0) begin
                            state_d = OFF;
                        end
                    end
                end
            end
            default: begin
                state_d = OFF;
                ramp_d  = '0;
            end
        endcase
    end

    // Outputs drop to zero on the same edge that enters OFF, and stay there.
    assign clr = (state_q == OFF) || (state_d == OFF);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= OFF;
            cnt_q   <= '0;
            ramp_q  <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ramp_q  <= ramp_d;
            tick_q  <= tick;
        end
    end

`ifdef SID_PDM_DITHER_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else if (tick) begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign cin = lfsr_q[0];
`else
    assign cin = 1'b0;
`endif

    sid_sdm_ch #(
        .SAMPLE_W (SAMPLE_W)
    ) u_ch1 (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick_i (tick),
        .clr_i  (clr),
        .eff_i  (eff_1),
        .cin_i  (cin),
        .pdm_o  (pdm_1_o)
    );

    sid_sdm_ch #(
        .SAMPLE_W (SAMPLE_W)
    ) u_ch2 (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick_i (tick),
        .clr_i  (clr),
        .eff_i  (eff_2),
        .cin_i  (cin),
        .pdm_o  (pdm_2_o)
    );

    assign active_o = (state_q != OFF);
    assign tick_o   = tick_q;

endmodule

// File: tb/tb_sid_pdm_out.sv
// Self-checking bench for sid_pdm_out: a behavioural model of the ramp, divider
// and modulator is compared against the DUT outputs every cycle, and directed
// sequences pin the model with hand-computed values.
module tb_sid_pdm_out;

    localparam int INC  = 256;
    localparam int MAXV = 4095;
    localparam int FULL = 4096;

    localparam int M_OFF  = 0;
    localparam int M_RAMP = 1;
    localparam int M_RUN  = 2;
    localparam int M_FALL = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] s1 = '0;
    logic [11:0] s2 = '0;
    logic        en = 1'b0;
    logic [7:0]  div = '0;
    logic        mono = 1'b0;
    logic        pdm1, pdm2, act, tck;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    sid_pdm_out #(
        .SAMPLE_W (12),
        .DIV_W    (8),
        .RAMP_INC (INC)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .sample_raw_1 (s1),
        .sample_raw_2 (s2),
        .enable_i     (en),
        .div_i        (div),
        .mono_i       (mono),
        .pdm_1_o      (pdm1),
        .pdm_2_o      (pdm2),
        .active_o     (act),
        .tick_o       (tck)
    );

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Behavioural model: state is tracked as plain integers.
    int m_state = M_OFF;
    int m_cnt   = 0;
    int m_ramp  = 0;
    int m_acc1  = 0;
    int m_acc2  = 0;
    bit m_p1    = 1'b0;
    bit m_p2    = 1'b0;
    bit m_tick  = 1'b0;

    always @(posedge clk) begin : model
        int run, tk, c1, c2, e1, e2, ns, nr, t1, t2;
        bit up;
        if (rst) begin
            m_state = M_OFF; m_cnt = 0; m_ramp = 0;
            m_acc1 = 0; m_acc2 = 0; m_p1 = 0; m_p2 = 0; m_tick = 0;
        end else begin
            run = (m_state != M_OFF || en) ? 1 : 0;
            tk  = (run != 0 && m_cnt >= int'(div)) ? 1 : 0;
            if (mono) begin
                c1 = (int'(s1) + int'(s2)) / 2;
                c2 = c1;
            end else begin
                c1 = int'(s1);
                c2 = int'(s2);
            end
            e1 = imin(c1, m_ramp);
            e2 = imin(c2, m_ramp);
            ns = m_state;
            nr = m_ramp;
            if (m_state == M_OFF) begin
                nr = 0;
                if (en) ns = M_RAMP;
            end else if (tk != 0) begin
                // Moving with the enable steps the ramp; against it only flips direction.
                up = (m_state == M_RAMP || m_state == M_RUN);
                if (en != up) begin
                    ns = en ? M_RAMP : M_FALL;
                end else if (up) begin
                    nr = imin(m_ramp + INC, MAXV);
                    ns = (nr == MAXV) ? M_RUN : M_RAMP;
                end else begin
                    nr = imax(m_ramp - INC, 0);
                    ns = (nr == 0) ? M_OFF : M_FALL;
                end
            end
            if (m_state == M_OFF || ns == M_OFF) begin
                m_acc1 = 0; m_acc2 = 0; m_p1 = 0; m_p2 = 0;
            end else if (tk != 0) begin
                t1 = m_acc1 + e1;
                t2 = m_acc2 + e2;
                m_p1 = (t1 >= FULL);
                m_p2 = (t2 >= FULL);
                m_acc1 = t1 % FULL;
                m_acc2 = t2 % FULL;
            end
            if (run != 0) m_cnt = (tk != 0) ? 0 : m_cnt + 1;
            m_tick  = (tk != 0);
            m_state = ns;
            m_ramp  = nr;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cycle_outputs {pdm1,pdm2,active,tick}", int'({pdm1, pdm2, act, tck}),
                  int'({m_p1, m_p2, (m_state != M_OFF), m_tick}));
        end
    end

    task automatic wait_tick(input int bound, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!tck && k < bound);
    endtask

    task automatic wait_run(input int bound);
        int k = 0;
        while (m_state != M_RUN && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("reach_run", m_state, M_RUN);
    endtask

    task automatic count_ticks(input int n, output int o1, output int o2, output int mis);
        int got = 0;
        int cyc = 0;
        o1 = 0; o2 = 0; mis = 0;
        while (got < n && cyc < n * 8 + 100) begin
            @(negedge clk);
            cyc++;
            if (tck) begin
                got++;
                o1 += int'(pdm1);
                o2 += int'(pdm2);
                if (pdm1 != pdm2) mis++;
            end
        end
        check("tick_budget", got, n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int k, o1, o2, mis;
    bit prev;
    int ramp_exp [14] = '{0, 256, 512, 768, 1024, 1280, 1280, 1024, 768, 768, 768, 512, 256, 0};
    bit en_sched [14] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0};
    bit act_exp  [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};

    initial begin
        // Reset with enable held high.
        rst = 1'b1; en = 1'b1; div = 8'd2;
        @(posedge clk);
        cmp_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", int'({pdm1, pdm2, act, tck}), 0);
        end
        rst = 1'b0;
        wait_tick(20, k);
        check("first_tick_latency", k, 3);

        // Soft start to RUN at div 0, mid-scale samples.
        @(negedge clk);
        rst = 1'b1; en = 1'b0; div = 8'd0; s1 = 12'd2048; s2 = 12'd2048; mono = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_inactive", int'(act), 0);
        en = 1'b1;
        @(negedge clk);
        k = 1;
        check("active_rise", int'(act), 1);
        while (m_state != M_RUN && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("clocks_to_run", k, 17);
        prev = pdm1;
        repeat (16) begin
            @(negedge clk);
            check("half_scale_alternates", int'(pdm1 ^ prev), 1);
            prev = pdm1;
        end
        count_ticks(FULL, o1, o2, mis);
        check("ones_half_ch1", o1, 2048);
        check("ones_half_ch2", o2, 2048);

        // Density at div 3.
        @(negedge clk);
        s1 = 12'd1024; s2 = 12'd4095; div = 8'd3;
        wait_tick(10, k);
        wait_tick(10, k);
        check("tick_spacing_div3", k, 4);
        count_ticks(FULL, o1, o2, mis);
        check("ones_quarter_ch1", o1, 1024);
        check("ones_full_ch2", o2, 4095);

        // Mono mix from a clean start, so both channels must match bit for bit.
        do_reset();
        mono = 1'b1; s1 = 12'd4095; s2 = 12'd1; div = 8'd0; en = 1'b1;
        wait_run(100);
        count_ticks(FULL, o1, o2, mis);
        check("mono_ones_ch1", o1, 2048);
        check("mono_ones_ch2", o2, 2048);
        check("mono_identical", mis, 0);

        // Stop mid-ramp, re-enable during the fall, then stop for good.
        en = 1'b0;
        do_reset();
        mono = 1'b0; s1 = 12'd2048; s2 = 12'd2048;
        for (int i = 0; i < 14; i++) begin
            en = en_sched[i];
            @(negedge clk);
            check($sformatf("ramp_step%0d", i), m_ramp, ramp_exp[i]);
            check($sformatf("active_step%0d", i), int'(act), int'(act_exp[i]));
        end
        check("off_outputs_zero", int'({pdm1, pdm2}), 0);

        // Divider lowered below the running count.
        en = 1'b1;
        wait_run(100);
        @(negedge clk);
        div = 8'd255;
        repeat (200) @(negedge clk);
        check("model_cnt_200", m_cnt, 200);
        div = 8'd10;
        wait_tick(5, k);
        check("tick_after_div_drop", k, 1);
        wait_tick(30, k);
        check("tick_spacing_div10_a", k, 11);
        wait_tick(30, k);
        check("tick_spacing_div10_b", k, 11);

        // Randomised traffic against the model.
        div = 8'd0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            s1 = 12'($urandom_range(0, 4095));
            s2 = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 149) == 0) en = ~en;
            if ($urandom_range(0, 99) == 0) div = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) mono = ~mono;
            rst = ($urandom_range(0, 999) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
